row_fetcher: RTL and testbench

ROW_FETCHER -- requirements
Module: row_fetcher

---
 rtl/row_fetcher_pkg.sv | 27 ++
 rtl/row_fetcher.sv | 113 +++++++++++
 tb/tb_row_fetcher.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/row_fetcher_pkg.sv
// Shared widths, FSM state encoding and row-to-word address helper for row_fetcher.
package row_fetcher_pkg;

    localparam int unsigned WORD_W        = 24;
    localparam int unsigned ROW_W         = 72;
    localparam int unsigned WORDS_PER_ROW = 3;
    localparam int unsigned NUM_ROWS      = 6;
    localparam int unsigned ADDR_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        DRAIN0,
        DRAIN1,
        HOLD
    } state_t;

    // First word address of a row: 3*row, computed as (row << 1) + row in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] row_base(input logic [2:0] r);
        logic [ADDR_W-1:0] r_ext;
        r_ext = {{(ADDR_W-3){1'b0}}, r};
        return (r_ext << 1) + r_ext;
    endfunction

endpackage

// File: rtl/row_fetcher.sv
// Fetches one 72-bit row as three 24-bit words from a registered-read memory and holds it
// until accepted. Define ROW_CHECK_EN to reject row indices above 5 with a one-cycle err pulse.
module row_fetcher
    import row_fetcher_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        row,
    output logic              busy,
    output logic              DataMEMRead,
    output logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] R_data,
    output logic [ROW_W-1:0]  row_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              err
);

    state_t            state;
    logic              pending;
    logic [2:0]        pend_row;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              row_ok;

    // A request is taken only from an idle block with nothing already queued.
    assign accept = start && (state == IDLE) && !pending;

`ifdef ROW_CHECK_EN
    logic err_pulse;

    assign row_ok = (row < 3'(NUM_ROWS));
    assign err    = err_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= accept && !row_ok;
        end
    end
`else
    assign row_ok = 1'b1;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            pend_row    <= '0;
            base        <= '0;
            busy        <= 1'b0;
            DataMEMRead <= 1'b0;
            address     <= '0;
            row_data    <= '0;
            row_valid   <= 1'b0;
        end else begin
            pending <= accept && row_ok;
            if (accept) begin
                pend_row <= row;
            end

            // Memory returns word k one cycle after its strobe; it is captured at the end of
            // the cycle in which it is presented (states RD1, RD2, DRAIN0).
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        base        <= row_base(pend_row);
                        address     <= row_base(pend_row);
                        DataMEMRead <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RD0;
                    end
                end
                RD0: begin
                    address <= base + ADDR_W'(1);
                    state   <= RD1;
                end
                RD1: begin
                    address               <= base + ADDR_W'(2);
                    row_data[0 +: WORD_W] <= R_data;
                    state                 <= RD2;
                end
                RD2: begin
                    DataMEMRead                <= 1'b0;
                    row_data[WORD_W +: WORD_W] <= R_data;
                    state                      <= DRAIN0;
                end
                DRAIN0: begin
                    row_data[2*WORD_W +: WORD_W] <= R_data;
                    state                        <= DRAIN1;
                end
                DRAIN1: begin
                    row_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_fetcher.sv
// Directed bench for row_fetcher with a registered-read word memory preloaded with 0x100+i.
module tb_row_fetcher;
    import row_fetcher_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        row;
    logic              busy;
    logic              DataMEMRead;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] R_data;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic              err;

    logic [WORD_W-1:0] mem [0:63];
    int checks     = 0;
    int failures   = 0;
    int reads      = 0;
    int deliveries = 0;
    int r0;
    int d0;

    always #5 clk = ~clk;

    row_fetcher dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .row         (row),
        .busy        (busy),
        .DataMEMRead (DataMEMRead),
        .address     (address),
        .R_data      (R_data),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .err         (err)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 24'h000100 + 24'(i);
    end

    always @(posedge clk) begin
        if (DataMEMRead) R_data <= mem[address];
    end

    always @(negedge clk) begin
        if (DataMEMRead) reads <= reads + 1;
        if (row_valid && row_ready) deliveries <= deliveries + 1;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [2:0] r);
        start = 1'b1;
        row   = r;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; row = 3'd0; row_ready = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_rd", DataMEMRead, 0);
        check("rst_addr", address, 0);
        check("rst_valid", row_valid, 0);
        check("rst_err", err, 0);
        check("rst_data", row_data, 0);
        reset = 1'b0;

        // Row 2 with consumer ready: reads 6,7,8, valid after E+6.
        row_ready = 1'b1;
        r0 = reads;
        fetch(3'd2);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("t1_valid_%0d", i), row_valid, 72'(i == 6));
            check($sformatf("t1_busy_%0d", i), busy, 1);
            check($sformatf("t1_rd_%0d", i), DataMEMRead, 72'(i <= 3));
            if (i <= 3) check($sformatf("t1_addr_%0d", i), address, 72'(5 + i));
        end
        check("t1_data", row_data, 72'h000108_000107_000106);
        step();
        check("t1_valid_off", row_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_reads", 72'(reads - r0), 3);

        // Row 5 held for 10 cycles without ready.
        row_ready = 1'b0;
        fetch(3'd5);
        repeat (6) step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_valid_%0d", i), row_valid, 1);
            check($sformatf("t2_data_%0d", i), row_data, 72'h000111_000110_00010F);
            check($sformatf("t2_busy_%0d", i), busy, 1);
            step();
        end
        row_ready = 1'b1;
        step();
        check("t2_valid_off", row_valid, 0);
        check("t2_idle", busy, 0);

        // Extra starts during RD1 and in the handshake cycle are dropped.
        r0 = reads;
        d0 = deliveries;
        fetch(3'd1);
        step();
        step();
        start = 1'b1; row = 3'd3;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("t3_valid", row_valid, 1);
        check("t3_data", row_data, 72'h000105_000104_000103);
        start = 1'b1; row = 3'd4;
        step();
        start = 1'b0;
        repeat (8) step();
        check("t3_reads", 72'(reads - r0), 3);
        check("t3_rows", 72'(deliveries - d0), 1);
        check("t3_idle", busy, 0);

        // Reset in DRAIN0 abandons the fetch.
        fetch(3'd4);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_rd", DataMEMRead, 0);
        check("t4_addr", address, 0);
        check("t4_valid", row_valid, 0);
        check("t4_err", err, 0);
        check("t4_data", row_data, 0);
        d0 = deliveries;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t4_novalid_%0d", i), row_valid, 0);
        end
        check("t4_rows", 72'(deliveries - d0), 0);
        fetch(3'd0);
        repeat (6) step();
        check("t4_valid_new", row_valid, 1);
        check("t4_data_new", row_data, 72'h000102_000101_000100);
        step();

        // Row 7: rejected with an err pulse, or fetched from 21..23.
        r0 = reads;
        fetch(3'd7);
`ifdef ROW_CHECK_EN
        check("t5_err", err, 1);
        check("t5_busy0", busy, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("t5_err_%0d", i), err, 0);
            check($sformatf("t5_rd_%0d", i), DataMEMRead, 0);
            check($sformatf("t5_busy_%0d", i), busy, 0);
        end
        check("t5_reads", 72'(reads - r0), 0);
`else
        check("t5_err0", err, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("t5_err_%0d", i), err, 0);
            check($sformatf("t5_rd_%0d", i), DataMEMRead, 72'(i <= 3));
            if (i <= 3) check($sformatf("t5_addr_%0d", i), address, 72'(20 + i));
        end
        check("t5_valid", row_valid, 1);
        check("t5_data", row_data, 72'h000117_000116_000115);
        check("t5_reads", 72'(reads - r0), 3);
`endif
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
